// File: rtl/shift_seq_unit.sv
// Multicycle shifter: one bit position per clock, start/busy/done handshake.
// Optional rotate-right (op 100) is compiled in when SHIFT_ROTATE_EN is defined.
module shift_seq_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_SLL = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d, op_dec;
  logic [DATA_W-1:0]  data_q, data_d, step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               busy_q, done_q;

  // Undefined encodings (and ROR when not built in) collapse to NOP.
  always_comb begin
    op_dec = OP_NOP;
    case (op)
      3'b001: op_dec = OP_SLL;
      3'b010: op_dec = OP_SRL;
      3'b011: op_dec = OP_SRA;
`ifdef SHIFT_ROTATE_EN
      3'b100: op_dec = OP_ROR;
`endif
      default: op_dec = OP_NOP;
    endcase
  end

  always_comb begin
    step = data_q;
    case (op_q)
      OP_SLL: step = {data_q[DATA_W-2:0], 1'b0};
      OP_SRL: step = {1'b0, data_q[DATA_W-1:1]};
      OP_SRA: step = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROR: step = {data_q[0], data_q[DATA_W-1:1]};
`endif
      default: step = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          data_d  = data_in;
          op_d    = op_dec;
          cnt_d   = (op_dec == OP_NOP) ? '0 : shamt;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          data_d = step;
          cnt_d  = cnt_q - SHAMT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy/done come straight from flops so a state transition cannot glitch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= (state_d == S_SHIFT);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: stimulus pushes expected result/latency,
// a negedge monitor pops and compares on each done pulse.
module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] data;
    int unsigned lat;
    int unsigned cyc0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  shift_seq_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (busy || done) begin
        checks++;
        if (busy && done) begin
          errors++;
          $display("FAIL busy_done_excl: busy=%0b done=%0b required not both high", busy, done);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 at cycle %0d required no pending op", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if (data_out !== e.data) begin
            errors++;
            $display("FAIL result: data_out=%08h required %08h", data_out, e.data);
          end
          checks++;
          if (cyc - e.cyc0 != e.lat) begin
            errors++;
            $display("FAIL latency: done %0d cycles after start, required %0d", cyc - e.cyc0, e.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] exp_d, input int unsigned n);
    exp_t e;
    @(negedge clk);
    op = o; data_in = d; shamt = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.data = exp_d; e.lat = n + 1; e.cyc0 = cyc;
    sb.push_back(e);
    if (n > 0) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_after_start: busy=%0b required 1", busy);
      end
    end
  endtask

  task automatic wait_idle(input logic [31:0] exp_d);
    int k = 0;
    while ((sb.size() != 0 || busy || done) && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: still pending=%0d busy=%0b after 200 cycles, required idle", sb.size(), busy);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (data_out !== exp_d || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold: data_out=%08h busy=%0b done=%0b required %08h 0 0", data_out, busy, done, exp_d);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                     input logic [31:0] exp_d, input int unsigned n);
    issue(o, d, s, exp_d, n);
    wait_idle(exp_d);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; data_in = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data_out=%08h busy=%0b done=%0b required 0 0 0", data_out, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;

    run(3'b001, 32'h0000_0001, 5'd4,  32'h0000_0010, 4);
    run(3'b011, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31);
    run(3'b010, 32'h8000_0000, 5'd31, 32'h0000_0001, 31);
    run(3'b001, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);

    // start re-pulsed mid-shift must be ignored
    issue(3'b001, 32'h0000_0001, 5'd4, 32'h0000_0010, 4);
    @(negedge clk);
    start = 1'b1; data_in = 32'h0; op = 3'b010; shamt = 5'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle(32'h0000_0010);

    // async reset aborts a shift; no done may follow
    @(negedge clk);
    op = 3'b001; data_in = 32'h0000_0001; shamt = 5'd8; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: data_out=%08h busy=%0b done=%0b required 0 0 0", data_out, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run(3'b001, 32'h0000_0001, 5'd8, 32'h0000_0100, 8);

`ifdef SHIFT_ROTATE_EN
    run(3'b100, 32'h0000_0001, 5'd1, 32'h8000_0000, 1);
    run(3'b100, 32'h0000_000F, 5'd4, 32'hF000_0000, 4);
`else
    run(3'b100, 32'h0000_0001, 5'd1, 32'h0000_0001, 0);
    run(3'b100, 32'h0000_000F, 5'd4, 32'h0000_000F, 0);
`endif

    run(3'b000, 32'h1234_5678, 5'd7,  32'h1234_5678, 0);
    run(3'b111, 32'hCAFE_F00D, 5'd3,  32'hCAFE_F00D, 0);
    run(3'b011, 32'h7F00_0000, 5'd4,  32'h07F0_0000, 4);
    run(3'b011, 32'hF000_000F, 5'd2,  32'hFC00_0003, 2);
    run(3'b010, 32'hF000_000F, 5'd2,  32'h3C00_0003, 2);
    run(3'b001, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 31);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
